// File: rtl/otg_hpi_bus_sequencer.sv
// Avalon-MM slave that turns each read/write into one timed HPI chip-select/strobe
// cycle to the OTG controller, with programmable setup, strobe, hold and recovery.
module otg_hpi_bus_sequencer #(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned STROBE_CYCLES   = 2,
    parameter int unsigned HOLD_CYCLES     = 1,
    parameter int unsigned RECOVERY_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        RECOVER
    } state_t;

    localparam logic [3:0] C_SETUP    = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] C_STROBE   = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] C_HOLD     = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] C_RECOVERY = 4'(RECOVERY_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_is_read;
    logic       w_cnt_zero;

    assign w_cnt_zero      = (r_cnt == '0);
    assign avs_waitrequest = (r_state != DONE);

    // Pin values are loaded on the edge that enters each state, so they line up
    // with the state they belong to rather than lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_is_read    <= 1'b0;
            otg_cs_n     <= 1'b1;
            otg_rd_n     <= 1'b1;
            otg_wr_n     <= 1'b1;
            otg_data_oe  <= 1'b0;
            otg_addr     <= '0;
            otg_data_out <= '0;
            avs_readdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (avs_chipselect && (avs_read || avs_write)) begin
                        r_is_read   <= avs_read;
                        otg_addr    <= avs_address;
                        otg_cs_n    <= 1'b0;
                        otg_data_oe <= ~avs_read;
                        if (!avs_read) begin
                            otg_data_out <= avs_writedata;
                        end
                        r_cnt   <= C_SETUP;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_cnt_zero) begin
                        otg_rd_n <= ~r_is_read;
                        otg_wr_n <= r_is_read;
                        r_cnt    <= C_STROBE;
                        r_state  <= STROBE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (w_cnt_zero) begin
                        otg_rd_n <= 1'b1;
                        otg_wr_n <= 1'b1;
                        if (r_is_read) begin
                            avs_readdata <= otg_data_in;
                        end
                        r_cnt   <= C_HOLD;
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (w_cnt_zero) begin
                        otg_cs_n    <= 1'b1;
                        otg_data_oe <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_cnt   <= C_RECOVERY;
                    r_state <= RECOVER;
                end
                RECOVER: begin
                    if (w_cnt_zero) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otg_hpi_bus_sequencer.sv
// Directed bench for otg_hpi_bus_sequencer: default timing instance plus a
// slow-timing instance (S=3, P=4, H=2, R=2) selected through gated chipselect.
module tb_otg_hpi_bus_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_read;
    logic        avs_write;
    logic [15:0] avs_writedata;
    logic [15:0] otg_data_in;
    logic        sel;

    logic [15:0] rdata1, rdata2, dout1, dout2;
    logic [1:0]  addr1, addr2;
    logic        wait1, wait2, cs1, cs2, rd1, rd2, wr1, wr2, oe1, oe2;

    logic [15:0] m_rdata, m_dout;
    logic [1:0]  m_addr;
    logic        m_wait, m_cs_n, m_rd_n, m_wr_n, m_oe;
    logic [4:0]  m_pins;

    int unsigned total = 0;
    int unsigned bad   = 0;

    int unsigned m_done1, m_done2, m_again, m_rdlow, m_wrlow, m_cslow, m_oecnt, m_wrfirst;
    logic        m_viol;
    logic [15:0] m_rdata1, m_dout1;
    logic [1:0]  m_addr1;
    logic        flag;

    otg_hpi_bus_sequencer dut1 (
        .clk             (clk),
        .reset           (reset),
        .avs_address     (avs_address),
        .avs_chipselect  (avs_chipselect & ~sel),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (rdata1),
        .avs_waitrequest (wait1),
        .otg_addr        (addr1),
        .otg_cs_n        (cs1),
        .otg_rd_n        (rd1),
        .otg_wr_n        (wr1),
        .otg_data_out    (dout1),
        .otg_data_oe     (oe1),
        .otg_data_in     (otg_data_in)
    );

    otg_hpi_bus_sequencer #(
        .SETUP_CYCLES    (3),
        .STROBE_CYCLES   (4),
        .HOLD_CYCLES     (2),
        .RECOVERY_CYCLES (2)
    ) dut2 (
        .clk             (clk),
        .reset           (reset),
        .avs_address     (avs_address),
        .avs_chipselect  (avs_chipselect & sel),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (rdata2),
        .avs_waitrequest (wait2),
        .otg_addr        (addr2),
        .otg_cs_n        (cs2),
        .otg_rd_n        (rd2),
        .otg_wr_n        (wr2),
        .otg_data_out    (dout2),
        .otg_data_oe     (oe2),
        .otg_data_in     (otg_data_in)
    );

    assign m_rdata = sel ? rdata2 : rdata1;
    assign m_dout  = sel ? dout2  : dout1;
    assign m_addr  = sel ? addr2  : addr1;
    assign m_wait  = sel ? wait2  : wait1;
    assign m_cs_n  = sel ? cs2    : cs1;
    assign m_rd_n  = sel ? rd2    : rd1;
    assign m_wr_n  = sel ? wr2    : wr1;
    assign m_oe    = sel ? oe2    : oe1;
    assign m_pins  = {m_cs_n, m_rd_n, m_wr_n, m_oe, m_wait};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
    endtask

    // One access issued in cycle 0; cycle c is sampled 1 time unit after edge c.
    // With chain=1 a read to address 0 follows as soon as the first DONE is seen.
    task automatic run(input logic rd, input logic wr, input logic [1:0] a,
                       input logic [15:0] d, input logic [15:0] din_v,
                       input int unsigned drop_at, input logic chain,
                       input int unsigned ncyc);
        logic        cur_rd;
        logic        prev_cs_low;
        logic [15:0] prev_dout;
        m_done1 = 0; m_done2 = 0; m_again = 0; m_rdlow = 0; m_wrlow = 0;
        m_cslow = 0; m_oecnt = 0; m_wrfirst = 0; m_viol = 1'b0;
        m_rdata1 = '0; m_dout1 = '0; m_addr1 = '0;
        cur_rd = rd;
        prev_cs_low = 1'b0;
        prev_dout = m_dout;
        otg_data_in    = ~din_v;
        avs_address    = a;
        avs_writedata  = d;
        avs_read       = rd;
        avs_write      = wr;
        avs_chipselect = 1'b1;
        for (int unsigned c = 1; c <= ncyc; c++) begin
            tick();
            if (c == drop_at) avs_chipselect = 1'b0;
            if (c == 1) begin
                m_addr1 = m_addr;
                m_dout1 = m_dout;
            end
            if (m_done1 == 0) begin
                if (!m_rd_n) m_rdlow++;
                if (!m_wr_n) m_wrlow++;
                if (!m_cs_n) m_cslow++;
                if (m_oe) m_oecnt++;
                if (!m_wr_n && m_wrfirst == 0) m_wrfirst = c;
            end
            if (!m_wait) begin
                if (m_done1 == 0) begin
                    m_done1  = c;
                    m_rdata1 = m_rdata;
                end else if (m_done2 == 0) begin
                    m_done2 = c;
                end else begin
                    m_viol = 1'b1;
                end
            end
            if (m_done1 != 0 && c > m_done1 && !m_cs_n && m_again == 0) m_again = c;
            if (!m_rd_n && !m_wr_n) m_viol = 1'b1;
            if ((!m_rd_n || !m_wr_n) && m_cs_n) m_viol = 1'b1;
            if (cur_rd && m_oe) m_viol = 1'b1;
            if (!m_cs_n && prev_cs_low && m_dout != prev_dout) m_viol = 1'b1;
            prev_cs_low = ~m_cs_n;
            prev_dout   = m_dout;
            otg_data_in = !m_rd_n ? din_v : ~din_v;
            if (m_done1 != 0 && c == m_done1 + 1) begin
                if (chain) begin
                    avs_read       = 1'b1;
                    avs_write      = 1'b0;
                    avs_address    = 2'd0;
                    avs_chipselect = 1'b1;
                    cur_rd         = 1'b1;
                end else begin
                    idle_bus();
                end
            end
            if (m_done2 != 0 && c == m_done2 + 1) idle_bus();
        end
        idle_bus();
    endtask

    initial begin
        sel = 1'b0;
        reset = 1'b1;
        avs_address = '0;
        avs_writedata = '0;
        otg_data_in = '0;
        idle_bus();
        tick();
        tick();
        chk("reset_pins", 32'(m_pins), 32'b11101);
        chk("reset_addr", 32'(m_addr), 32'd0);
        chk("reset_dout", 32'(m_dout), 32'd0);
        chk("reset_rdata", 32'(m_rdata), 32'd0);
        reset = 1'b0;
        tick();

        // default read
        run(1'b1, 1'b0, 2'd0, 16'h0000, 16'h1234, 0, 1'b0, 8);
        chk("rd_done", m_done1, 32'd5);
        chk("rd_data", 32'(m_rdata1), 32'h1234);
        chk("rd_rdlow", m_rdlow, 32'd2);
        chk("rd_wrlow", m_wrlow, 32'd0);
        chk("rd_oe", m_oecnt, 32'd0);
        chk("rd_inv", 32'(m_viol), 32'd0);

        // default write
        run(1'b0, 1'b1, 2'd2, 16'hA5C3, 16'h0000, 0, 1'b0, 8);
        chk("wr_done", m_done1, 32'd5);
        chk("wr_addr", 32'(m_addr1), 32'd2);
        chk("wr_dout", 32'(m_dout1), 32'hA5C3);
        chk("wr_cslow", m_cslow, 32'd4);
        chk("wr_wrlow", m_wrlow, 32'd2);
        chk("wr_wrfirst", m_wrfirst, 32'd2);
        chk("wr_oe", m_oecnt, 32'd4);
        chk("wr_rdata_kept", 32'(m_rdata1), 32'h1234);
        chk("wr_inv", 32'(m_viol), 32'd0);

        // back-to-back write then read
        run(1'b0, 1'b1, 2'd1, 16'h0F0F, 16'hBEEF, 0, 1'b1, 14);
        chk("b2b_done1", m_done1, 32'd5);
        chk("b2b_again", m_again, 32'd8);
        chk("b2b_gap", 32'(m_again - m_done1 >= 2), 32'd1);
        chk("b2b_done2", m_done2, 32'd12);
        chk("b2b_rdata", 32'(m_rdata), 32'hBEEF);
        chk("b2b_inv", 32'(m_viol), 32'd0);

        // read and write together: read wins
        run(1'b1, 1'b1, 2'd3, 16'hFFFF, 16'h5A5A, 0, 1'b0, 8);
        chk("pri_done", m_done1, 32'd5);
        chk("pri_wrlow", m_wrlow, 32'd0);
        chk("pri_rdlow", m_rdlow, 32'd2);
        chk("pri_addr", 32'(m_addr1), 32'd3);
        chk("pri_data", 32'(m_rdata1), 32'h5A5A);
        chk("pri_inv", 32'(m_viol), 32'd0);

        // chipselect dropped at cycle 2 of a write
        run(1'b0, 1'b1, 2'd1, 16'h1111, 16'h0000, 2, 1'b0, 8);
        chk("abort_done", m_done1, 32'd5);
        chk("abort_wrlow", m_wrlow, 32'd2);
        chk("abort_inv", 32'(m_viol), 32'd0);

        // reset during STROBE of a read
        avs_address = 2'd0;
        avs_read = 1'b1;
        avs_chipselect = 1'b1;
        tick();
        tick();
        chk("mid_strobe", 32'(m_pins), 32'b00101);
        reset = 1'b1;
        tick();
        chk("mid_rst_pins", 32'(m_pins), 32'b11101);
        tick();
        reset = 1'b0;
        idle_bus();
        chk("mid_rst_rdata", 32'(m_rdata), 32'd0);
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!m_wait || !m_cs_n) flag = 1'b1;
        end
        chk("mid_no_done", 32'(flag), 32'd0);
        run(1'b0, 1'b1, 2'd2, 16'h4321, 16'h0000, 0, 1'b0, 8);
        chk("post_rst_done", m_done1, 32'd5);

        // slow timing instance, write then chained read
        sel = 1'b1;
        tick();
        run(1'b0, 1'b1, 2'd2, 16'h3C3C, 16'h7E7E, 0, 1'b1, 30);
        chk("sw_wrlow", m_wrlow, 32'd4);
        chk("sw_wrfirst", m_wrfirst, 32'd4);
        chk("sw_cslow", m_cslow, 32'd9);
        chk("sw_done1", m_done1, 32'd10);
        chk("sw_accept", m_again - 1, 32'd13);
        chk("sw_done2", m_done2, 32'd23);
        chk("sw_rdata", 32'(m_rdata), 32'h7E7E);
        chk("sw_inv", 32'(m_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
